sram_arbiter: RTL
=================

# sram_arbiter

Shares the single external async SRAM between three requesters: PPU CHR fetch (read-only, 16-bit), CHR loader (write-only, 16-bit, active during boot), and CPU PRG-RAM (8-bit read/write). It sits between those clients and the SRAM pins, replacing the loader's direct pin ownership. It sequences every access as a fixed-length read or write cycle with a recovery gap. Fixed priority is used, with optional CPU anti-starvation.

## Interface
- ACCESS_CYCLES, 2: cycles oe_n/we_n held low per access (legal 1..15)
- STARVE_LIMIT, 4: consecutive lost arbitrations before CPU is forced to win (only with SRAM_ARB_STARVE_EN)
- i_clk  in  1  PPU clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_ppu_req / i_ppu_addr  in  1 / 20  PPU word read request, word address
- o_ppu_ack / o_ppu_rdata  out  1 / 16  one-cycle completion pulse, read word
- i_ld_req / i_ld_addr / i_ld_wdata  in  1 / 20 / 16  loader word write request
- o_ld_ack  out  1  one-cycle completion pulse
- i_cpu_req / i_cpu_we / i_cpu_addr / i_cpu_wdata  in  1 / 1 / 21 / 8  CPU byte request; addr[0] selects lane (0=lb, 1=ub)
- o_cpu_ack / o_cpu_rdata  out  1 / 8  completion pulse, selected read byte
- o_sram_addr / o_sram_wdata  out  20 / 16  SRAM pins
- o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n  out  1 each  SRAM strobes, active low
- o_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE: when any req is high, pick the winner: PPU > loader > CPU (starvation override below). On the edge:
  - register addr, wdata and lanes;
  - read → oe_n=0; write → we_n=0;
  - load counter = ACCESS_CYCLES−1; go to ACCESS.
- Lanes per requester:
  - PPU and loader: both lanes (ub_n=lb_n=0).
  - CPU: lane from addr[0], other lane 1. Write data is replicated on both bytes of o_sram_wdata.
- ACCESS: counter decrements each cycle. The edge leaving counter==0 does the following:
  - capture i_sram_rdata into the winner's rdata register (CPU: byte per addr[0]);
  - raise that winner's ack for exactly one cycle;
  - drive oe_n=we_n=1 and ub_n=lb_n=1;
  - go to RECOVER.
- RECOVER: one cycle, o_sram_addr/o_sram_wdata held, strobes high; then IDLE.
- rdata registers hold their value until the next read by the same requester.
- Requester rules:
  - hold req, addr and data stable until ack;
  - drop req no later than the cycle ack is high. A req still high in IDLE after ack is a new request.
- Once granted, an access is never aborted. Dropping req early still yields ack.
- Reset values: state IDLE; all strobes 1; o_sram_addr=0; o_sram_wdata=0; all acks 0; all rdata 0; o_busy 0; starvation counter 0.
- i_rst asserted in ACCESS or RECOVER: the next edge forces the reset values and discards the access (no ack).

## Timing
- Req high in IDLE at edge t: strobes low from t+1 to t+ACCESS_CYCLES; ack high in cycle t+ACCESS_CYCLES+1 (RECOVER); IDLE at t+ACCESS_CYCLES+2.
- Earliest next grant edge: t+ACCESS_CYCLES+2. Back-to-back period = ACCESS_CYCLES+2 cycles (4 at default).
- Address is stable one cycle before an ack and one cycle after strobes release, giving write setup and hold.
- No combinational path from any req to any SRAM pin or ack.

## Configuration
- SRAM_ARB_STARVE_EN defined:
  - a 4-bit counter increments on each IDLE grant where i_cpu_req=1 but the CPU loses, and saturates at STARVE_LIMIT;
  - at STARVE_LIMIT, the next IDLE arbitration with i_cpu_req=1 grants the CPU over PPU and loader;
  - the counter clears on any CPU grant.
- Undefined: strict PPU > loader > CPU priority; counter logic absent.

## Test plan
- Loader write addr 0x00123, data 0xBEEF, ACCESS_CYCLES=2 → we_n low 2 cycles, ub_n=lb_n=0, o_ld_ack on 3rd cycle after grant edge, period 4.
- PPU read addr 0x00040 with SRAM model returning 0x5A3C → o_ppu_rdata=0x5A3C with o_ppu_ack; oe_n low exactly 2 cycles.
- CPU write 0x7E to addr 0x00005, then read back → write asserts ub_n=0/lb_n=1 on word 0x00002; read returns 0x7E.
- PPU, loader and CPU req in the same cycle, all held → grants in order PPU, loader, CPU; acks 4 cycles apart.
- PPU req held continuously plus CPU req, macro on, STARVE_LIMIT=4 → CPU granted on 5th arbitration. Macro off → CPU never granted.
- i_rst pulsed mid-ACCESS of a CPU write → strobes high next cycle, no o_cpu_ack, state IDLE, o_busy 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// Fixed-priority arbiter sharing one async SRAM between PPU reads, loader writes and CPU byte accesses.
// Optional CPU anti-starvation override enabled by defining SRAM_ARB_STARVE_EN.
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ppu_req,
    input  logic [19:0] i_ppu_addr,
    output logic        o_ppu_ack,
    output logic [15:0] o_ppu_rdata,
    input  logic        i_ld_req,
    input  logic [19:0] i_ld_addr,
    input  logic [15:0] i_ld_wdata,
    output logic        o_ld_ack,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [20:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    input  logic [15:0] i_sram_rdata,
    output logic [19:0] o_sram_addr,
    output logic [15:0] o_sram_wdata,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n,
    output logic        o_sram_ub_n,
    output logic        o_sram_lb_n,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    localparam logic [1:0] OWN_PPU  = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] owner, winner;
    logic       is_wr, cpu_lane;
    logic [3:0] cnt;
    logic       any_req, cpu_force, strobe_on;

    assign any_req = i_ppu_req | i_ld_req | i_cpu_req;

`ifdef SRAM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign cpu_force = i_cpu_req && (starve_cnt == STARVE_MAX);

    // Counts grants the CPU lost while asking; cleared whenever the CPU wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE && any_req) begin
            if (winner == OWN_CPU)
                starve_cnt <= '0;
            else if (i_cpu_req && starve_cnt < STARVE_MAX)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign cpu_force = 1'b0;
`endif

    always_comb begin
        winner = OWN_CPU;
        if (cpu_force)      winner = OWN_CPU;
        else if (i_ppu_req) winner = OWN_PPU;
        else if (i_ld_req)  winner = OWN_LD;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data latched at grant and held through RECOVER for write hold time.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            owner        <= OWN_PPU;
            is_wr        <= 1'b0;
            cpu_lane     <= 1'b0;
            cnt          <= '0;
            o_ppu_rdata  <= '0;
            o_cpu_rdata  <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner <= winner;
                    cnt   <= CNT_INIT;
                    case (winner)
                        OWN_PPU: begin
                            o_sram_addr <= i_ppu_addr;
                            is_wr       <= 1'b0;
                        end
                        OWN_LD: begin
                            o_sram_addr  <= i_ld_addr;
                            o_sram_wdata <= i_ld_wdata;
                            is_wr        <= 1'b1;
                        end
                        default: begin
                            o_sram_addr  <= i_cpu_addr[20:1];
                            o_sram_wdata <= {i_cpu_wdata, i_cpu_wdata};
                            is_wr        <= i_cpu_we;
                            cpu_lane     <= i_cpu_addr[0];
                        end
                    endcase
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!is_wr) begin
                        if (owner == OWN_PPU)
                            o_ppu_rdata <= i_sram_rdata;
                        else if (owner == OWN_CPU)
                            o_cpu_rdata <= cpu_lane ? i_sram_rdata[15:8] : i_sram_rdata[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and acks decode from registered state only: no req-to-pin path.
    always_comb begin
        strobe_on   = (state == ACCESS);
        o_sram_oe_n = !(strobe_on && !is_wr);
        o_sram_we_n = !(strobe_on && is_wr);
        o_sram_ub_n = !(strobe_on && (owner != OWN_CPU || cpu_lane));
        o_sram_lb_n = !(strobe_on && (owner != OWN_CPU || !cpu_lane));
        o_ppu_ack   = (state == RECOVER) && (owner == OWN_PPU);
        o_ld_ack    = (state == RECOVER) && (owner == OWN_LD);
        o_cpu_ack   = (state == RECOVER) && (owner == OWN_CPU);
        o_busy      = (state != IDLE);
    end

endmodule
